// File: rtl/cache_controller.sv
// Sequencing FSM for a direct-mapped write-back cache array: lookup, dirty
// write-back, block refill with retry, memory timeout and saturating statistics.
module cache_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req_valid,
  input  logic             cpu_req_type,
  output logic             cpu_ready,
  output logic             cpu_done,
  output logic             cpu_err,
  input  logic             hit,
  input  logic             dirty_bit,
  output logic             req_type,
  output logic             read_en_cache,
  output logic             write_en_cache,
  output logic             refill,
  output logic             mem_rd_req,
  output logic             mem_wr_req,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    REFILL,
    RESPOND
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] tmo_cnt;
  logic        looked;
  logic        err_q;
  logic        mem_wait;
  logic        tmo_fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // tmo_cnt holds the number of waiting cycles already spent in this phase;
  // the limit cycle still accepts mem_ack as success.
  assign mem_wait = (state == WRITEBACK) || (state == ALLOCATE);
  assign tmo_fire = mem_wait && !mem_ack && (tmo_cnt == TMO_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_type   <= 1'b0;
      looked     <= 1'b0;
      err_q      <= 1'b0;
      tmo_cnt    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      state <= state_nxt;
      err_q <= tmo_fire;

      if (state == IDLE && cpu_req_valid) begin
        req_type <= cpu_req_type;
        looked   <= 1'b0;
      end

      // Only the first lookup of a request is a statistic; retries are not.
      if (state == COMPARE) begin
        looked <= 1'b1;
        if (!looked) begin
          if (hit) hit_count  <= sat_inc(hit_count);
          else     miss_count <= sat_inc(miss_count);
        end
      end

      if (state == WRITEBACK && mem_ack) wb_count <= sat_inc(wb_count);

      if (mem_wait && state_nxt == state) tmo_cnt <= tmo_cnt + 16'd1;
      else                                tmo_cnt <= '0;
    end
  end

  // NOTE: every output and next-state is given a default first, so no path
  // through the case can infer a latch.
  always_comb begin
    state_nxt      = state;
    cpu_ready      = 1'b0;
    cpu_done       = 1'b0;
    cpu_err        = 1'b0;
    read_en_cache  = 1'b0;
    write_en_cache = 1'b0;
    refill         = 1'b0;
    mem_rd_req     = 1'b0;
    mem_wr_req     = 1'b0;

    unique case (state)
      IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req_valid) state_nxt = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          read_en_cache  = !req_type;
          write_en_cache = req_type;
          state_nxt      = RESPOND;
        end else if (dirty_bit) begin
          read_en_cache = 1'b1;
          state_nxt     = WRITEBACK;
        end else begin
          state_nxt = ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_wr_req = 1'b1;
        if (mem_ack)       state_nxt = ALLOCATE;
        else if (tmo_fire) state_nxt = RESPOND;
      end
      ALLOCATE: begin
        mem_rd_req = 1'b1;
        if (mem_ack)       state_nxt = REFILL;
        else if (tmo_fire) state_nxt = RESPOND;
      end
      REFILL: begin
        refill    = 1'b1;
        state_nxt = COMPARE;
      end
      RESPOND: begin
        cpu_done  = 1'b1;
        cpu_err   = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller: two instances (timeout 5 / 16-bit
// counters, timeout 4 / 2-bit counters) checked cycle by cycle against a latency script.
module tb_cache_controller;

  localparam int T0 = 5;
  localparam int T1 = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic valid_i [2];
  logic type_i  [2];
  logic hit_i   [2];
  logic dirty_i [2];
  logic ack_i   [2];

  logic [8:0]  obs_vec  [2];
  logic [15:0] obs_hit  [2];
  logic [15:0] obs_miss [2];
  logic [15:0] obs_wb   [2];

  logic        a_rdy, a_done, a_err, a_rt, a_re, a_we, a_rf, a_mrd, a_mwr;
  logic [15:0] a_hit, a_miss, a_wb;
  logic        b_rdy, b_done, b_err, b_rt, b_re, b_we, b_rf, b_mrd, b_mwr;
  logic [1:0]  b_hit, b_miss, b_wb;

  cache_controller #(.MEM_TIMEOUT(T0), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(valid_i[0]), .cpu_req_type(type_i[0]),
    .cpu_ready(a_rdy), .cpu_done(a_done), .cpu_err(a_err),
    .hit(hit_i[0]), .dirty_bit(dirty_i[0]), .req_type(a_rt),
    .read_en_cache(a_re), .write_en_cache(a_we), .refill(a_rf),
    .mem_rd_req(a_mrd), .mem_wr_req(a_mwr), .mem_ack(ack_i[0]),
    .hit_count(a_hit), .miss_count(a_miss), .wb_count(a_wb)
  );

  cache_controller #(.MEM_TIMEOUT(T1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(valid_i[1]), .cpu_req_type(type_i[1]),
    .cpu_ready(b_rdy), .cpu_done(b_done), .cpu_err(b_err),
    .hit(hit_i[1]), .dirty_bit(dirty_i[1]), .req_type(b_rt),
    .read_en_cache(b_re), .write_en_cache(b_we), .refill(b_rf),
    .mem_rd_req(b_mrd), .mem_wr_req(b_mwr), .mem_ack(ack_i[1]),
    .hit_count(b_hit), .miss_count(b_miss), .wb_count(b_wb)
  );

  assign obs_vec[0]  = {a_rdy, a_done, a_err, a_rt, a_re, a_we, a_rf, a_mrd, a_mwr};
  assign obs_vec[1]  = {b_rdy, b_done, b_err, b_rt, b_re, b_we, b_rf, b_mrd, b_mwr};
  assign obs_hit[0]  = a_hit;
  assign obs_miss[0] = a_miss;
  assign obs_wb[0]   = a_wb;
  assign obs_hit[1]  = {14'd0, b_hit};
  assign obs_miss[1] = {14'd0, b_miss};
  assign obs_wb[1]   = {14'd0, b_wb};

  always #5 clk = ~clk;

  int   n_vec;
  int   n_err;
  int   m_hit  [2];
  int   m_miss [2];
  int   m_wb   [2];
  logic m_rt   [2];
  int   tmo [2] = '{T0, T1};
  int   cw  [2] = '{16, 2};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Expected output vector: {ready, done, err, req_type, rd_en, wr_en, refill, mem_rd, mem_wr}
  function automatic logic [8:0] ev(input logic rdy, done, err, rt, re, we, rf, mrd, mwr);
    return {rdy, done, err, rt, re, we, rf, mrd, mwr};
  endfunction

  function automatic logic [15:0] sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return 16'((v > mx) ? mx : v);
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      m_hit[k]  = 0;
      m_miss[k] = 0;
      m_wb[k]   = 0;
      m_rt[k]   = 1'b0;
    end
  endtask

  task automatic check_cnt(input int d);
    check("hit_count",  obs_hit[d],  sat(m_hit[d],  cw[d]));
    check("miss_count", obs_miss[d], sat(m_miss[d], cw[d]));
    check("wb_count",   obs_wb[d],   sat(m_wb[d],   cw[d]));
  endtask

  // Drive one cycle's inputs at the falling edge, then compare the outputs.
  task automatic step(input int d, input logic v, input logic t, input logic h, input logic dy,
                      input logic ack, input logic r, input logic [8:0] exp, input string tag);
    @(negedge clk);
    rst_n      = r;
    valid_i[d] = v;
    type_i[d]  = t;
    hit_i[d]   = h;
    dirty_i[d] = dy;
    ack_i[d]   = ack;
    #2;
    check(tag, {7'd0, obs_vec[d]}, {7'd0, exp});
  endtask

  task automatic idle(input int d);
    step(d, 1'b0, rb(), rb(), rb(), rb(), 1'b1, ev(1, 0, 0, m_rt[d], 0, 0, 0, 0, 0), "idle");
    check_cnt(d);
  endtask

  // One request: dw/da are the waiting cycle on which mem_ack arrives for the
  // write-back/allocate phases (beyond the timeout means it never arrives).
  task automatic run_txn(input int d, input logic t, input logic h0, input logic dy,
                         input int dw, input int da, input int retry_miss, input bit rst_wb);
    int   looks;
    int   tl;
    bit   err;
    bit   fin;
    bit   rn;
    logic h;
    looks = 0;
    err   = 1'b0;
    fin   = 1'b0;
    tl    = tmo[d];
    step(d, 1'b1, t, rb(), rb(), rb(), 1'b1, ev(1, 0, 0, m_rt[d], 0, 0, 0, 0, 0), "idle_accept");
    check_cnt(d);
    m_rt[d] = t;
    while (!fin) begin
      h = (looks == 0) ? h0 : ((looks <= retry_miss) ? 1'b0 : 1'b1);
      if (looks == 0) begin
        if (h) m_hit[d]++;
        else   m_miss[d]++;
      end
      if (h) begin
        step(d, rb(), rb(), 1'b1, rb(), rb(), 1'b1, ev(0, 0, 0, t, !t, t, 0, 0, 0), "compare_hit");
        fin = 1'b1;
      end else begin
        step(d, rb(), rb(), 1'b0, dy, rb(), 1'b1, ev(0, 0, 0, t, dy, 0, 0, 0, 0), "compare_miss");
        if (dy) begin
          for (int i = 1; i <= min2(dw, tl); i++) begin
            rn = rst_wb && (i == 2);
            step(d, rb(), rb(), rb(), rb(), (i == dw) && !rn, !rn,
                 ev(0, 0, 0, t, 0, 0, 0, 0, 1), "writeback");
            if (rn) begin
              clear_model();
              return;
            end
          end
          if (dw > tl) begin
            err = 1'b1;
            fin = 1'b1;
          end else begin
            m_wb[d]++;
          end
        end
        if (!fin) begin
          for (int i = 1; i <= min2(da, tl); i++)
            step(d, rb(), rb(), rb(), rb(), i == da, 1'b1,
                 ev(0, 0, 0, t, 0, 0, 0, 1, 0), "allocate");
          if (da > tl) begin
            err = 1'b1;
            fin = 1'b1;
          end else begin
            step(d, rb(), rb(), rb(), rb(), rb(), 1'b1, ev(0, 0, 0, t, 0, 0, 1, 0, 0), "refill");
            looks++;
          end
        end
      end
    end
    step(d, rb(), rb(), rb(), rb(), rb(), 1'b1, ev(0, 1, err, t, 0, 0, 0, 0, 0),
         err ? "respond_err" : "respond");
  endtask

  task automatic rand_txn(input int d);
    int span;
    span = tmo[d] + 2;
    run_txn(d, rb(), ($urandom_range(2, 0) != 0), rb(),
            1 + int'($urandom_range(span - 1, 0)), 1 + int'($urandom_range(span - 1, 0)),
            ($urandom_range(7, 0) == 0) ? 1 : 0, ($urandom_range(39, 0) == 0));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clear_model();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      valid_i[k] = 1'b0;
      type_i[k]  = 1'b0;
      hit_i[k]   = 1'b0;
      dirty_i[k] = 1'b0;
      ack_i[k]   = 1'b0;
    end
    repeat (2) @(negedge clk);

    idle(0);
    idle(1);
    run_txn(0, 1'b0, 1'b1, 1'b0, 1, 1, 0, 1'b0);  // read hit
    run_txn(0, 1'b1, 1'b1, 1'b0, 1, 1, 0, 1'b0);  // write hit
    run_txn(0, 1'b0, 1'b0, 1'b0, 1, 5, 0, 1'b0);  // clean read miss, ack on limit cycle
    run_txn(0, 1'b1, 1'b0, 1'b1, 3, 2, 0, 1'b0);  // dirty write miss
    run_txn(0, 1'b0, 1'b0, 1'b0, 1, 1, 1, 1'b0);  // retry lookup misses once
    run_txn(0, 1'b1, 1'b0, 1'b1, 7, 1, 0, 1'b0);  // write-back timeout
    run_txn(0, 1'b1, 1'b0, 1'b1, 4, 1, 0, 1'b1);  // reset during write-back
    idle(0);
    repeat (150) rand_txn(0);
    idle(0);

    run_txn(1, 1'b0, 1'b0, 1'b0, 1, 5, 0, 1'b0);  // allocate timeout
    run_txn(1, 1'b0, 1'b0, 1'b0, 1, 4, 0, 1'b0);  // ack on limit cycle
    step(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(1, 0, 0, m_rt[1], 0, 0, 0, 0, 0), "reset_idle");
    clear_model();
    repeat (5) run_txn(1, 1'b0, 1'b1, 1'b0, 1, 1, 0, 1'b0);
    idle(1);
    repeat (100) rand_txn(1);
    idle(1);
    idle(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
